// File: rtl/boot_uart_pkg.sv
// Purpose : shared types and helpers for the UART boot loader (FSM states, header layout, word assembly).
// Latency : n/a (declarations only).
// Backpressure : n/a. With BOOT_UART_CSUM_EN defined, the FSM gains the ACK state.
package boot_uart_pkg;

  // Header word layout: [31] write/read, [30:16] start address, [15:0] word count.
  localparam int HDR_WR_BIT   = 31;
  localparam int HDR_ADDR_MSB = 30;
  localparam int HDR_ADDR_LSB = 16;
  localparam int HDR_CNT_MSB  = 15;
  localparam int HDR_CNT_LSB  = 0;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_WR_DATA,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_SEND
`ifdef BOOT_UART_CSUM_EN
    ,ST_ACK
`endif
  } state_t;

  // lo_bytes holds the first three bytes with the oldest byte in [7:0].
  function automatic logic [31:0] assemble_word(input logic [23:0] lo_bytes,
                                                input logic [7:0]  last_byte);
    return {last_byte, lo_bytes};
  endfunction

endpackage

// File: rtl/boot_uart_ctrl_if.sv
// Purpose : bundles the UART byte streams, memory-target bus and status lines of boot_uart_ctrl.
// Latency : n/a (wires only).
// Backpressure : tx side is valid/ready; rx side is a strobe with no backpressure.
// Ports   : master = controller side, slave = UART/memory/CPU environment side.
interface boot_uart_ctrl_if #(
  parameter int N_TARGETS = 2,
  parameter int AW        = 10
);
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic [N_TARGETS-1:0]    mem_en;
  logic                    mem_we;
  logic [AW-1:0]           mem_addr;
  logic [31:0]             mem_wdata;
  logic [N_TARGETS*32-1:0] mem_rdata;
  logic                    busy;
  logic                    done;

  modport master (
    input  rx_data, rx_valid, tx_ready, mem_rdata,
    output tx_data, tx_valid, mem_en, mem_we, mem_addr, mem_wdata, busy, done
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, mem_rdata,
    input  tx_data, tx_valid, mem_en, mem_we, mem_addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/boot_uart_txser.sv
// Purpose : serialises one 32-bit word into 4 bytes, LSB first.
// Latency : first byte valid the cycle after start; each byte held until tx_ready.
// Backpressure : tx_valid/tx_data stay stable while tx_ready is low; last pulses on the 4th handshake.
// Ports   : clk, rst_n, start/word (load), tx_data/tx_valid/tx_ready (byte stream), last (final byte accepted).
module boot_uart_txser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] word,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        last
);

  logic [23:0] rest;
  logic [1:0]  idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      rest     <= 24'h0;
      idx      <= 2'd0;
    end else if (start) begin
      tx_data  <= word[7:0];
      rest     <= word[31:8];
      tx_valid <= 1'b1;
      idx      <= 2'd0;
    end else if (tx_valid && tx_ready) begin
      if (idx == 2'd3) begin
        tx_valid <= 1'b0;
      end else begin
        tx_data <= rest[7:0];
        rest    <= {8'h00, rest[23:8]};
        idx     <= idx + 2'd1;
      end
    end
  end

  assign last = tx_valid && tx_ready && (idx == 2'd3);

endmodule

// File: rtl/boot_uart_ctrl.sv
// Purpose : UART boot loader; parses a header word, then writes N words to / reads N words from a memory target.
// Latency : mem strobe the cycle after the 4th byte; read data leaves via boot_uart_txser 3 cycles after mem_en.
// Backpressure : rx is never stalled (ignored outside HDR/WR_DATA); tx bytes held until tx_ready.
// Ports   : clk, rst_n (sync, active-low), bus (boot_uart_ctrl_if.master).
// Config  : BOOT_UART_CSUM_EN adds the ACK state that returns the XOR of all written words.
module boot_uart_ctrl
  import boot_uart_pkg::*;
#(
  parameter int N_TARGETS   = 2,
  parameter int AW          = 10,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  boot_uart_ctrl_if.master bus
);

  localparam int TW  = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
  localparam int TMW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMW-1:0] TMO_LAST = TMW'(TIMEOUT_CYC - 1);

  state_t               state;
  logic [1:0]           byte_cnt;
  logic [23:0]          lo_bytes;
  logic [TMW-1:0]       tmo;
  logic [AW-1:0]        addr;
  logic [TW-1:0]        tgt;
  logic                 tgt_ok;
  logic [15:0]          cnt;
  logic                 done_pend;
  logic                 rd_ph;
  logic                 tx_start;
  logic [31:0]          tx_word;
  logic                 tx_last;
  logic [N_TARGETS-1:0] mem_en;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [31:0]          mem_wdata;
  logic                 done;
`ifdef BOOT_UART_CSUM_EN
  logic [31:0]          csum;
`endif

  logic [31:0]          cur_word;
  logic [TW-1:0]        hdr_tgt;
  logic                 hdr_ok;
  logic [N_TARGETS-1:0] tgt_onehot;
  logic [31:0]          rd_word;
  logic                 unused_hdr_bits;

  assign cur_word = assemble_word(lo_bytes, bus.rx_data);

  // Only address bits above the word address select the target; higher bits are don't-care.
  if (N_TARGETS > 1) begin : g_multi
    assign hdr_tgt = cur_word[HDR_ADDR_LSB + AW +: TW];
  end else begin : g_single
    assign hdr_tgt = '0;
  end
  assign unused_hdr_bits = ^cur_word[HDR_ADDR_MSB:HDR_ADDR_LSB];

  assign hdr_ok     = 32'(hdr_tgt) < N_TARGETS;
  assign tgt_onehot = tgt_ok ? (N_TARGETS'(1) << tgt) : '0;
  // Non-existent targets read back as zero.
  assign rd_word    = tgt_ok ? bus.mem_rdata[32*tgt +: 32] : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_HDR;
      byte_cnt  <= 2'd0;
      lo_bytes  <= 24'h0;
      tmo       <= '0;
      addr      <= '0;
      tgt       <= '0;
      tgt_ok    <= 1'b0;
      cnt       <= 16'h0;
      done_pend <= 1'b0;
      rd_ph     <= 1'b0;
      tx_start  <= 1'b0;
      tx_word   <= 32'h0;
      mem_en    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      done      <= 1'b0;
`ifdef BOOT_UART_CSUM_EN
      csum      <= 32'h0;
`endif
    end else begin
      mem_en    <= '0;
      mem_we    <= 1'b0;
      tx_start  <= 1'b0;
      done      <= done_pend;
      done_pend <= 1'b0;
      case (state)
        ST_HDR: begin
          if (bus.rx_valid) begin
            tmo <= '0;
            if (byte_cnt != 2'd3) begin
              lo_bytes <= {bus.rx_data, lo_bytes[23:8]};
              byte_cnt <= byte_cnt + 2'd1;
            end else begin
              byte_cnt <= 2'd0;
              addr     <= cur_word[HDR_ADDR_LSB +: AW];
              tgt      <= hdr_tgt;
              tgt_ok   <= hdr_ok;
              cnt      <= cur_word[HDR_CNT_MSB:HDR_CNT_LSB];
`ifdef BOOT_UART_CSUM_EN
              csum     <= 32'h0;
`endif
              if (cur_word[HDR_CNT_MSB:HDR_CNT_LSB] == 16'h0) begin
                done <= 1'b1;
              end else if (cur_word[HDR_WR_BIT]) begin
                state <= ST_WR_DATA;
              end else begin
                state <= ST_RD_REQ;
              end
            end
          end else if (byte_cnt != 2'd0) begin
            // Stale partial header: drop it silently.
            if (tmo == TMO_LAST) begin
              byte_cnt <= 2'd0;
              tmo      <= '0;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
        end

        ST_WR_DATA: begin
          if (bus.rx_valid) begin
            tmo <= '0;
            if (byte_cnt != 2'd3) begin
              lo_bytes <= {bus.rx_data, lo_bytes[23:8]};
              byte_cnt <= byte_cnt + 2'd1;
            end else begin
              byte_cnt  <= 2'd0;
              mem_en    <= tgt_onehot;
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= cur_word;
              addr      <= addr + 1'b1;
              cnt       <= cnt - 16'd1;
`ifdef BOOT_UART_CSUM_EN
              csum      <= csum ^ cur_word;
`endif
              if (cnt == 16'd1) begin
`ifdef BOOT_UART_CSUM_EN
                state    <= ST_ACK;
                tx_word  <= csum ^ cur_word;
                tx_start <= 1'b1;
`else
                state     <= ST_HDR;
                done_pend <= 1'b1;
`endif
              end
            end
          end else if (tmo == TMO_LAST) begin
            // Host went quiet mid-write: abandon the transfer without done.
            state    <= ST_HDR;
            byte_cnt <= 2'd0;
            tmo      <= '0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        ST_RD_REQ: begin
          mem_en   <= tgt_onehot;
          mem_addr <= addr;
          addr     <= addr + 1'b1;
          rd_ph    <= 1'b0;
          state    <= ST_RD_WAIT;
        end

        // mem_en is visible during the first RD_WAIT cycle; rdata is valid in the second.
        ST_RD_WAIT: begin
          if (!rd_ph) begin
            rd_ph <= 1'b1;
          end else begin
            rd_ph    <= 1'b0;
            tx_word  <= rd_word;
            tx_start <= 1'b1;
            state    <= ST_RD_SEND;
          end
        end

        ST_RD_SEND: begin
          if (tx_last) begin
            cnt <= cnt - 16'd1;
            if (cnt == 16'd1) begin
              done  <= 1'b1;
              state <= ST_HDR;
            end else begin
              state <= ST_RD_REQ;
            end
          end
        end

`ifdef BOOT_UART_CSUM_EN
        ST_ACK: begin
          if (tx_last) begin
            done  <= 1'b1;
            state <= ST_HDR;
          end
        end
`endif

        default: state <= ST_HDR;
      endcase
    end
  end

  boot_uart_txser u_txser (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (tx_start),
    .word     (tx_word),
    .tx_data  (bus.tx_data),
    .tx_valid (bus.tx_valid),
    .tx_ready (bus.tx_ready),
    .last     (tx_last)
  );

  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.done      = done;
  assign bus.busy      = (state != ST_HDR) || (byte_cnt != 2'd0) || done_pend;

endmodule

// File: tb/tb_boot_uart_ctrl.sv
// Purpose : scoreboard bench for boot_uart_ctrl (3 targets, AW = 10, short inter-byte timeout).
// Latency : n/a.
// Backpressure : tx_ready is driven by the bench, including a long stall during a read.
module tb_boot_uart_ctrl;

  localparam int NT  = 3;
  localparam int AW  = 10;
  localparam int TMO = 64;

  typedef struct packed {
    logic [1:0]  tgt;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   done_cnt;

  logic [7:0] exp_tx[$];
  wr_t        exp_wr[$];

  logic [31:0] mem [NT][1024];
  logic [31:0] rd_q [NT];
  logic        pl_en;
  logic [1:0]  pl_t;
  logic [9:0]  pl_a;
  logic [31:0] pl_d;

  logic       prev_vld;
  logic       prev_rdy;
  logic [7:0] prev_dat;

  boot_uart_ctrl_if #(.N_TARGETS(NT), .AW(AW)) bus ();

  boot_uart_ctrl #(.N_TARGETS(NT), .AW(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = {rd_q[2], rd_q[1], rd_q[0]};

  // Memory targets: synchronous read, one-cycle latency; bench preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_t][pl_a] <= pl_d;
    for (int t = 0; t < NT; t++) begin
      if (bus.mem_en[t]) begin
        if (bus.mem_we) mem[t][bus.mem_addr] <= bus.mem_wdata;
        else            rd_q[t] <= mem[t][bus.mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a tx byte or a memory write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) done_cnt++;
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0) begin
          tests++; fails++;
          $display("FAIL tx_unexpected: got byte %0h, expected no byte", bus.tx_data);
        end else begin
          chk("tx_byte", {56'h0, bus.tx_data}, {56'h0, exp_tx.pop_front()});
        end
      end
      if (bus.mem_we && (bus.mem_en != '0)) begin
        wr_t act;
        act.tgt  = 2'd0;
        for (int t = 0; t < NT; t++) if (bus.mem_en[t]) act.tgt = 2'(t);
        act.addr = bus.mem_addr;
        act.data = bus.mem_wdata;
        chk("mem_en_onehot", 64'($countones(bus.mem_en)), 64'd1);
        if (exp_wr.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_unexpected: got write %0h, expected none", act);
        end else begin
          chk("mem_write", {20'h0, act}, {20'h0, exp_wr.pop_front()});
        end
      end
      if (prev_vld && !prev_rdy) begin
        chk("tx_hold", {55'h0, bus.tx_valid, bus.tx_data}, {55'h0, 1'b1, prev_dat});
      end
    end
    prev_vld = bus.tx_valid;
    prev_rdy = bus.tx_ready;
    prev_dat = bus.tx_data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_tx_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
  endtask

  task automatic push_csum(input logic [31:0] w);
`ifdef BOOT_UART_CSUM_EN
    push_tx_word(w);
`else
    if (w == 32'hFFFF_FFFF) $display("csum word %0h", w);
`endif
  endtask

  task automatic push_wr(input logic [1:0] t, input logic [9:0] a, input logic [31:0] d);
    wr_t e;
    e.tgt = t; e.addr = a; e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic preload(input logic [1:0] t, input logic [9:0] a, input logic [31:0] d);
    pl_t = t; pl_a = a; pl_d = d; pl_en = 1'b1;
    tick(1);
    pl_en = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 3000) begin
      tick(1);
      n++;
    end
    if (n >= 3000) begin
      tests++; fails++;
      $display("FAIL %s_timeout: busy still %0b after %0d cycles, expected 0", name, bus.busy, n);
    end
    tick(4);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_valid"},  {63'h0, bus.tx_valid}, 64'h0);
    chk({tag, "_tx_data"},   {56'h0, bus.tx_data},  64'h0);
    chk({tag, "_mem_en"},    {61'h0, bus.mem_en},   64'h0);
    chk({tag, "_mem_we"},    {63'h0, bus.mem_we},   64'h0);
    chk({tag, "_mem_addr"},  {54'h0, bus.mem_addr}, 64'h0);
    chk({tag, "_mem_wdata"}, {32'h0, bus.mem_wdata},64'h0);
    chk({tag, "_busy"},      {63'h0, bus.busy},     64'h0);
    chk({tag, "_done"},      {63'h0, bus.done},     64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    tests = 0; fails = 0; done_cnt = 0;
    rst_n = 1'b0;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b1;
    pl_en = 1'b0; pl_t = 2'd0; pl_a = 10'd0; pl_d = 32'h0;
    tick(3);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // Three-word write to target 0, addresses 0..2; checksum 11^22^33 = 0.
    d0 = done_cnt;
    push_wr(2'd0, 10'h000, 32'h1111_1111);
    push_wr(2'd0, 10'h001, 32'h2222_2222);
    push_wr(2'd0, 10'h002, 32'h3333_3333);
    push_csum(32'h0000_0000);
    send_word(32'h8000_0003);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    wait_quiet("wr3");
    chk("wr3_done", 64'(done_cnt - d0), 64'd1);

    // Single-word read of target 1 word 5.
    preload(2'd1, 10'd5, 32'hDEAD_BEEF);
    d0 = done_cnt;
    push_tx_word(32'hDEAD_BEEF);
    send_word(32'h0405_0001);
    wait_quiet("rd1");
    chk("rd1_done", 64'(done_cnt - d0), 64'd1);

    // Two-word read with a long tx stall before the first byte is accepted.
    preload(2'd0, 10'h010, 32'h0403_0201);
    preload(2'd0, 10'h011, 32'h0807_0605);
    d0 = done_cnt;
    push_tx_word(32'h0403_0201);
    push_tx_word(32'h0807_0605);
    bus.tx_ready = 1'b0;
    send_word(32'h0010_0002);
    tick(100);
    chk("stall_valid", {63'h0, bus.tx_valid}, 64'h1);
    chk("stall_data",  {56'h0, bus.tx_data},  64'h01);
    bus.tx_ready = 1'b1;
    wait_quiet("rd_stall");
    chk("rd_stall_done", 64'(done_cnt - d0), 64'd1);

    // Address wrap within target 0: 0x3FF then 0x000; target 1 must see nothing.
    d0 = done_cnt;
    push_wr(2'd0, 10'h3FF, 32'hA5A5_0001);
    push_wr(2'd0, 10'h000, 32'hA5A5_0002);
    push_csum(32'h0000_0003);
    send_word(32'h83FF_0002);
    send_word(32'hA5A5_0001);
    send_word(32'hA5A5_0002);
    wait_quiet("wrap");
    chk("wrap_done", 64'(done_cnt - d0), 64'd1);

    // Target 3 does not exist: write is dropped, read returns zero.
    d0 = done_cnt;
    push_csum(32'h1234_5678);
    send_word(32'h8C00_0001);
    send_word(32'h1234_5678);
    wait_quiet("oor_wr");
    push_tx_word(32'h0000_0000);
    send_word(32'h0C07_0001);
    wait_quiet("oor_rd");
    chk("oor_done", 64'(done_cnt - d0), 64'd2);

    // Partial header times out after exactly TMO idle cycles, then a zero-count header.
    d0 = done_cnt;
    send_byte(8'hAB);
    send_byte(8'hCD);
    chk("tmo_busy_partial", {63'h0, bus.busy}, 64'h1);
    tick(TMO - 1);
    chk("tmo_busy_before", {63'h0, bus.busy}, 64'h1);
    tick(1);
    chk("tmo_busy_after", {63'h0, bus.busy}, 64'h0);
    tick(1);
    send_word(32'h0000_0000);
    tick(4);
    chk("tmo_hdr_done", 64'(done_cnt - d0), 64'd1);

    // Reset in the middle of a two-word write, then a clean write.
    d0 = done_cnt;
    push_wr(2'd0, 10'h020, 32'h0BAD_F00D);
    send_word(32'h8020_0002);
    send_word(32'h0BAD_F00D);
    tick(2);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk_reset_outputs("midrst");
    tick(2);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    d0 = done_cnt;
    push_wr(2'd0, 10'h030, 32'hCAFE_0001);
    push_csum(32'hCAFE_0001);
    send_word(32'h8030_0001);
    send_word(32'hCAFE_0001);
    wait_quiet("post_rst");
    chk("post_rst_done", 64'(done_cnt - d0), 64'd1);

    tick(10);
    chk("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
